// File: rtl/mdu_unit.sv
// mdu_unit: HI/LO multiply-divide unit for a 5-stage MIPS-style pipeline.
// MULT/MULTU/DIV/DIVU complete into HI/LO after a fixed busy window.
// MTHI/MTLO write HI/LO immediately, with no busy cycle.
// Optional divider: define MDU_DIV_EN to build DIV/DIVU. When it is not
// defined, DIV/DIVU behave as no-ops.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        hi_nxt, lo_nxt;
  logic [31:0]        res_hi, res_lo, res_hi_nxt, res_lo_nxt;
  logic               res_wr, res_wr_nxt;
  logic               busy_nxt;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;

  // Full 64-bit products; the sign-extended form yields the signed product modulo 2^64
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'b0, A} * {32'b0, B};
  end

`ifdef MDU_DIV_EN
  logic        div_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] q_mag, r_mag;
  logic [31:0] quo, rem;
  logic        div_zero;

  // Magnitude divide with sign fix-up; 0x80000000 / -1 wraps to 0x80000000 with no trap
  always_comb begin
    div_signed = (op == OP_DIV);
    div_zero   = (B == 32'd0);
    a_neg      = div_signed & A[31];
    b_neg      = div_signed & B[31];
    a_mag      = a_neg ? 32'(-A) : A;
    b_mag      = b_neg ? 32'(-B) : B;
    q_mag      = 32'd0;
    r_mag      = 32'd0;
    if (!div_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? 32'(-q_mag) : q_mag;
    rem = a_neg ? 32'(-r_mag) : r_mag;
  end
`endif

  // Next-state, counter and HI/LO update logic
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_nxt     = HI_out;
    lo_nxt     = LO_out;
    res_hi_nxt = res_hi;
    res_lo_nxt = res_lo;
    res_wr_nxt = res_wr;

    case (state)
      IDLE: begin
        if (start && !req) begin
          case (op)
            OP_MULT: begin
              res_hi_nxt = prod_s[63:32];
              res_lo_nxt = prod_s[31:0];
              res_wr_nxt = 1'b1;
              cnt_nxt    = CNT_W'(MULT_CYCLES);
              state_nxt  = RUN;
            end
            OP_MULTU: begin
              res_hi_nxt = prod_u[63:32];
              res_lo_nxt = prod_u[31:0];
              res_wr_nxt = 1'b1;
              cnt_nxt    = CNT_W'(MULT_CYCLES);
              state_nxt  = RUN;
            end
            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
              res_hi_nxt = rem;
              res_lo_nxt = quo;
              res_wr_nxt = !div_zero;
              cnt_nxt    = CNT_W'(DIV_CYCLES);
              state_nxt  = RUN;
`endif
            end
            OP_MTHI: hi_nxt = A;
            OP_MTLO: lo_nxt = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt <= CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (res_wr) begin
            hi_nxt = res_hi;
            lo_nxt = res_lo;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == RUN);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      HI_out <= '0;
      LO_out <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      HI_out <= hi_nxt;
      LO_out <= lo_nxt;
      res_hi <= res_hi_nxt;
      res_lo <= res_lo_nxt;
      res_wr <= res_wr_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed plus random stimulus against a behavioural HI/LO model.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        req;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI_out;
  logic [31:0] LO_out;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
    .A(A), .B(B), .busy(busy), .HI_out(HI_out), .LO_out(LO_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: remaining busy cycles plus the pending architectural result
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
  bit          m_rwr = 0;
`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  always @(posedge clk) begin
    longint sa, sb, q, r;
    logic [63:0] p;
    if (!reset) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_rhi = '0; m_rlo = '0; m_rwr = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_rwr) begin
        m_hi = m_rhi;
        m_lo = m_rlo;
      end
    end else if (start && !req) begin
      case (op)
        3'd1: begin
          sa = longint'($signed(A));
          sb = longint'($signed(B));
          p  = 64'(sa * sb);
          m_rhi = p[63:32]; m_rlo = p[31:0]; m_rwr = 1; m_left = MC;
        end
        3'd2: begin
          p = {32'b0, A} * {32'b0, B};
          m_rhi = p[63:32]; m_rlo = p[31:0]; m_rwr = 1; m_left = MC;
        end
        3'd3, 3'd4: begin
          if (DIV_ON) begin
            if (op == 3'd3) begin
              sa = longint'($signed(A));
              sb = longint'($signed(B));
            end else begin
              sa = longint'({32'b0, A});
              sb = longint'({32'b0, B});
            end
            m_left = DC;
            m_rwr  = (B != 32'd0);
            if (B != 32'd0) begin
              q = sa / sb;
              r = sa % sb;
              m_rlo = 32'(q);
              m_rhi = 32'(r);
            end
          end
        end
        3'd5: m_hi = A;
        3'd6: m_lo = A;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy_vs_model", 32'(busy), (m_left > 0) ? 32'd1 : 32'd0);
      chk("hi_vs_model", HI_out, m_hi);
      chk("lo_vs_model", LO_out, m_lo);
    end
  end

  task automatic drive_idle();
    start = 0; req = 0; op = 3'd0; A = '0; B = '0;
  endtask

  // Present one request for a single cycle, then drop start
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
    start = 1; op = o; A = a; B = b; req = r;
    @(negedge clk);
    drive_idle();
  endtask

  // Count cycles with busy high, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL busy_timeout actual=%0d expected=<100", n);
    end
  endtask

  task automatic expect_op(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int ncyc,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(o, a, b, 1'b0);
    count_busy(n);
    chk({name, "_busy_cycles"}, 32'(n), 32'(ncyc));
    chk({name, "_hi"}, HI_out, ehi);
    chk({name, "_lo"}, LO_out, elo);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    drive_idle();
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("reset_hi", HI_out, 32'h0);
    chk("reset_lo", LO_out, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    check_en = 1;

    expect_op("mult_neg", 3'd1, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
    expect_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'd2, MC, 32'h00000001, 32'hFFFFFFFE);
    if (DIV_ON) begin
      expect_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
      expect_op("divu_zero", 3'd4, 32'd7, 32'd0, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
      expect_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, DC, 32'h0, 32'h80000000);
    end else begin
      expect_op("div_off", 3'd3, 32'hFFFFFFF9, 32'd2, 0, 32'h00000001, 32'hFFFFFFFE);
      expect_op("divu_off", 3'd4, 32'd7, 32'd0, 0, 32'h00000001, 32'hFFFFFFFE);
    end

    // MTHI writes with no busy cycle
    issue(3'd5, 32'h12345678, 32'd0, 1'b0);
    chk("mthi_hi", HI_out, 32'h12345678);
    chk("mthi_busy", 32'(busy), 32'h0);

    // MTLO presented while busy is ignored
    issue(3'd1, 32'd3, 32'd4, 1'b0);
    start = 1; op = 3'd6; A = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    drive_idle();
    count_busy(n);
    chk("mtlo_busy_lo", LO_out, 32'd12);
    chk("mtlo_busy_hi", HI_out, 32'd0);

    // Flush blocks acceptance
    issue(3'd1, 32'd9, 32'd9, 1'b1);
    chk("req_block_busy", 32'(busy), 32'h0);
    chk("req_block_lo", LO_out, 32'd12);

    // Flush during RUN does not abort
    issue(3'd2, 32'd6, 32'd7, 1'b0);
    req = 1;
    count_busy(n);
    req = 0;
    chk("req_run_cycles", 32'(n), 32'(MC));
    chk("req_run_lo", LO_out, 32'd42);

    // Held request stalls, then is accepted back-to-back
    start = 1; op = 3'd1; A = 32'd5; B = 32'd7;
    repeat (2 * MC + 4) @(negedge clk);
    drive_idle();
    count_busy(n);
    chk("held_lo", LO_out, 32'd35);

    // Reset in the middle of a long operation
    issue(3'd5, 32'hAAAA5555, 32'd0, 1'b0);
    issue(DIV_ON ? 3'd3 : 3'd1, 32'd100, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_hi", HI_out, 32'h0);
    chk("midreset_lo", LO_out, 32'h0);
    @(negedge clk);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = $urandom_range(1, 9);
        default: ;
      endcase
      start = ($urandom_range(0, 2) != 0);
      op    = 3'($urandom_range(0, 7));
      A     = ra;
      B     = rb;
      req   = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    drive_idle();
    reset = 1;
    repeat (DC + 2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration of MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration of DIV/DIVU.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req  input  1  exception flush of the EX-stage instruction, active-high.
REQ-006 SHALL have port start  input  1  EX-stage instruction is an MDU operation this cycle.
REQ-007 SHALL have port op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE.
REQ-008 SHALL have port A  input  32  rs operand, taken from the ID/EX register.
REQ-009 SHALL have port B  input  32  rt operand, taken from the ID/EX register.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port HI_out  output  32  current HI register.
REQ-012 SHALL have port LO_out  output  32  current LO register.

Function
REQ-013 SHALL accept an operation only at an edge where start=1, req=0 and busy=0; all other edges ignore start, op, A and B.
REQ-014 SHALL use a two-state FSM: IDLE (busy=0) and RUN (busy=1), with a down-counter of width >= clog2(max(MULT_CYCLES, DIV_CYCLES))+1.
REQ-015 SHALL, on an accepted MULT/MULTU/DIV/DIVU, latch the result internally, load the counter with N (MULT_CYCLES or DIV_CYCLES) and enter RUN.
REQ-016 SHALL timing: accept at edge T -> busy=1 for exactly N cycles after T -> at edge T+N, HI/LO are written, busy=0, FSM returns to IDLE.
REQ-017 SHALL keep HI_out/LO_out at their old values while busy=1.
REQ-018 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned 32x32->64, with HI = bits 63:32 and LO = bits 31:0.
REQ-019 SHALL compute DIV as signed: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend; DIVU as unsigned.
REQ-020 SHALL handle DIV 0x80000000 / 0xFFFFFFFF as LO=0x80000000, HI=0.
REQ-021 SHALL, on division by zero, still run busy for DIV_CYCLES and leave HI/LO unchanged at completion.
REQ-022 SHALL, on an accepted MTHI/MTLO, write A into HI/LO at that same edge, with no busy cycle.
REQ-023 SHALL treat op NONE with start=1 as a no-op.
REQ-024 SHALL keep an operation in RUN going to completion when req asserts; req only blocks new acceptance.
REQ-025 SHALL, with start=1 and busy=1 (the hazard unit stalls on busy|start for MDU ops), ignore the new request; the held instruction is accepted after busy falls.
REQ-026 SHALL allow back-to-back issue: an accept is legal at edge T+N+1.

Reset
REQ-027 SHALL, at an edge with reset=0, clear HI, LO, the latched result and the counter to 0, set busy=0 and put the FSM in IDLE, overriding all other inputs including an operation in progress.
REQ-028 SHALL produce HI_out=0, LO_out=0 and busy=0 in the cycle after reset is released.

Configuration
REQ-029 SHALL, when macro MDU_DIV_EN is defined, implement DIV/DIVU per REQ-016 and REQ-019 to REQ-021.
REQ-030 SHALL, when MDU_DIV_EN is undefined, omit the divider, treat DIV/DIVU as no-ops (no busy, HI/LO unchanged), and leave all other ops unaffected.

Verification
REQ-031 SHALL cover: MULT A=0xFFFFFFFE (-2), B=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 SHALL cover: MULTU A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged.
REQ-034 SHALL cover: MTHI A=0x12345678 -> HI_out=0x12345678 the next cycle, busy stays 0; MTLO issued while busy is ignored.
REQ-035 SHALL cover: start MULT with req=1 -> busy stays 0 and HI/LO unchanged; req=1 during RUN -> result still written.
REQ-036 SHALL cover: reset=0 at cycle 3 of a DIV -> next cycle busy=0, HI=0, LO=0; with MDU_DIV_EN undefined, DIV -> busy never rises.
